// File: rtl/lfsr_rng_if.sv
// Request/valid bundle between the game controller and the LFSR random number generator.
// Master drives requests and seeding; slave returns the draw, status and raw LFSR state.
interface lfsr_rng_if #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 12
);
  logic                 req;
  logic [OUT_WIDTH-1:0] limit;
  logic                 free_run;
  logic                 seed_load;
  logic [WIDTH-1:0]     seed_value;
  logic [OUT_WIDTH-1:0] rnd;
  logic                 valid;
  logic                 busy;
  logic [WIDTH-1:0]     state_out;

  modport master (
    output req, limit, free_run, seed_load, seed_value,
    input  rnd, valid, busy, state_out
  );

  modport slave (
    input  req, limit, free_run, seed_load, seed_value,
    output rnd, valid, busy, state_out
  );
endinterface

// File: rtl/lfsr_rng.sv
// Galois-LFSR random number generator: draws uniform values in [0, limit) by
// rejection sampling, with seed loading and a free-running entropy mode between draws.
module lfsr_rng #(
  parameter int             WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
  parameter int             OUT_WIDTH = 12,
  parameter int             STEPS     = 16
) (
  input  logic       clock,
  input  logic       reset,
  lfsr_rng_if.slave  bus
);
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     lfsr_reg, lfsr_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [OUT_WIDTH-1:0] limit_reg, limit_next;
  logic [OUT_WIDTH-1:0] mask_reg, mask_next;
  logic [OUT_WIDTH-1:0] rnd_reg, rnd_next;
  logic                 valid_reg, valid_next;
  logic                 busy_reg, busy_next;

  logic [WIDTH-1:0]     lfsr_step;
  logic [OUT_WIDTH-1:0] candidate;
  logic                 accept;

  // One Galois step: shift right, fold the TAPS mask in when the outgoing bit is 1.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_step
      assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
    end
  endgenerate
  assign lfsr_step[WIDTH-1] = TAPS[WIDTH-1] & lfsr_reg[0];

  // Smallest 2^k-1 covering limit-1; limit 0 wraps to all ones, i.e. full range.
  function automatic logic [OUT_WIDTH-1:0] mask_of(input logic [OUT_WIDTH-1:0] lim);
    logic [OUT_WIDTH-1:0] m;
    m = lim - OUT_WIDTH'(1);
    for (int i = 1; i < OUT_WIDTH; i++) begin
      m = m | (m >> i);
    end
    return (lim == '0) ? '1 : m;
  endfunction

  assign candidate = lfsr_reg[OUT_WIDTH-1:0] & mask_reg;
  assign accept    = (limit_reg == '0) || (candidate < limit_reg);

  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    cnt_next   = cnt_reg;
    limit_next = limit_reg;
    mask_next  = mask_reg;
    rnd_next   = rnd_reg;
    valid_next = 1'b0;
    busy_next  = busy_reg;

    if (bus.seed_load) begin
      // An all-zero seed would lock the LFSR, so it is replaced by all ones.
      lfsr_next  = (bus.seed_value == '0) ? '1 : bus.seed_value;
      state_next = IDLE;
      busy_next  = 1'b0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          busy_next = 1'b0;
          if (bus.req) begin
            limit_next = bus.limit;
            mask_next  = mask_of(bus.limit);
            cnt_next   = '0;
            busy_next  = 1'b1;
            state_next = SHIFT;
          end else if (bus.free_run) begin
            lfsr_next = lfsr_step;
          end
        end
        SHIFT: begin
          lfsr_next = lfsr_step;
          if (cnt_reg == LAST_STEP) begin
            cnt_next   = '0;
            state_next = CHECK;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        CHECK: begin
          if (accept) begin
            rnd_next   = candidate;
            valid_next = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
        default: begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      lfsr_reg  <= '1;
      cnt_reg   <= '0;
      limit_reg <= '0;
      mask_reg  <= '0;
      rnd_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      cnt_reg   <= cnt_next;
      limit_reg <= limit_next;
      mask_reg  <= mask_next;
      rnd_reg   <= rnd_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
    end
  end

  assign bus.rnd       = rnd_reg;
  assign bus.valid     = valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.state_out = lfsr_reg;
endmodule
